// File: rtl/sync_chain.sv
// Multi-bit N-flop synchronizer for asynchronous inputs.
// Every bit has its own flop chain, and all stages clear on reset.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // NOTE: sequential state uses non-blocking assignments so that all stages shift in parallel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Per-channel synchronizer, sample-based symmetric debouncer and edge detector.
// One sample timer drives the debouncers of every channel.
module input_conditioner #(
    parameter int WIDTH          = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int SAMPLE_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int PULSE_W  = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(PULSE_CNT_MAX - 1);

    logic [WIDTH-1:0] synced;

    sync_chain #(
        .WIDTH (WIDTH),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst),
        .async_i(async_in),
        .sync_o (synced)
    );

    logic [SAMPLE_W-1:0] sample_cnt_q, sample_cnt_d;
    logic                tick;

    assign tick = (sample_cnt_q == SAMPLE_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sample_cnt_d = sample_cnt_q + SAMPLE_W'(1);
        if (tick) begin
            sample_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [PULSE_W-1:0] cnt_q, cnt_d;
        logic               level_q, level_d;

        // A sample that agrees with the current level restarts the run of disagreeing samples.
        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            if (tick) begin
                if (synced[i] == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == PULSE_LAST) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PULSE_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
            end
        end

        assign level_out[i] = level_q;
    end

    logic [WIDTH-1:0] level_dly_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_dly_q <= '0;
        end else begin
            level_dly_q <= level_out;
        end
    end

    assign rise_pulse = level_out & ~level_dly_q;
    assign fall_pulse = ~level_out & level_dly_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: a vector table plus hand-written timing and reset sequences.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] async_in = 2'b00;
    logic [1:0] level_out, rise_pulse, fall_pulse;

    input_conditioner #(
        .WIDTH         (2),
        .SYNC_STAGES   (2),
        .SAMPLE_CNT_MAX(4),
        .PULSE_CNT_MAX (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int r0, r1, f0, f1;

    typedef struct {
        logic [1:0] din;
        int         hold;
        logic [1:0] lvl;
        int         r0, r1, f0, f1;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rise_pulse[0]) r0++;
        if (rise_pulse[1]) r1++;
        if (fall_pulse[0]) f0++;
        if (fall_pulse[1]) f1++;
    endtask

    task automatic clear_counts();
        r0 = 0; r1 = 0; f0 = 0; f1 = 0;
    endtask

    initial begin
        int n;
        int nz;
        int quiet;
        logic [1:0] pulse_at_flip;

        vecs[0] = '{2'b00, 20, 2'b00, 0, 0, 1, 1};
        vecs[1] = '{2'b01, 20, 2'b01, 1, 0, 0, 0};
        vecs[2] = '{2'b11, 20, 2'b11, 0, 1, 0, 0};
        vecs[3] = '{2'b10, 20, 2'b10, 0, 0, 1, 0};
        vecs[4] = '{2'b00, 20, 2'b00, 0, 0, 0, 1};
        vecs[5] = '{2'b10,  3, 2'b00, 0, 0, 0, 0};
        vecs[6] = '{2'b00, 20, 2'b00, 0, 0, 0, 0};

        // Reset held with both inputs high: every output must stay 0.
        #2 rst = 1'b0;
        async_in = 2'b11;
        #1;
        check("reset immediate", {level_out, rise_pulse, fall_pulse}, 0);
        nz = 0;
        repeat (10) begin
            step();
            if ({level_out, rise_pulse, fall_pulse} != 6'b0) nz++;
        end
        check("reset hold cycles nonzero", nz, 0);

        rst = 1'b1;
        cyc = 0;
        clear_counts();
        n = 0;
        while (level_out != 2'b11 && n < 25) begin
            step();
            n++;
        end
        check_range("release latency", n, 1, 15);
        check("release rise pulse", rise_pulse, 2'b11);
        step();
        check("release rise width", rise_pulse, 2'b00);
        repeat (5) step();
        check("release rise count", r0 + r1, 2);

        // Table of settled input patterns.
        for (int i = 0; i < 7; i++) begin
            clear_counts();
            async_in = vecs[i].din;
            repeat (vecs[i].hold) step();
            check($sformatf("vec%0d level", i), level_out, vecs[i].lvl);
            check($sformatf("vec%0d rise0", i), r0, vecs[i].r0);
            check($sformatf("vec%0d rise1", i), r1, vecs[i].r1);
            check($sformatf("vec%0d fall0", i), f0, vecs[i].f0);
            check($sformatf("vec%0d fall1", i), f1, vecs[i].f1);
        end

        // Clean press on channel 0.
        clear_counts();
        async_in = 2'b01;
        n = 0;
        quiet = 0;
        while (level_out[0] != 1'b1 && n < 25) begin
            step();
            n++;
            if (level_out[1] | rise_pulse[1] | fall_pulse[1]) quiet++;
        end
        check_range("press latency", n, 11, 15);
        pulse_at_flip = rise_pulse;
        check("press rise pulse", pulse_at_flip, 2'b01);
        repeat (6) begin
            step();
            if (level_out[1] | rise_pulse[1] | fall_pulse[1]) quiet++;
        end
        check("press rise count", r0, 1);
        check("press ch1 activity", quiet, 0);

        // Release on channel 0.
        clear_counts();
        async_in = 2'b00;
        n = 0;
        while (level_out[0] != 1'b0 && n < 25) begin
            step();
            n++;
        end
        check_range("release0 latency", n, 11, 15);
        check("release0 fall pulse", fall_pulse, 2'b01);
        repeat (6) step();
        check("release0 fall count", f0, 1);
        check("release0 rise count", r0, 0);

        // Bounce: toggle once per sample period for 10 periods, then hold high.
        while (cyc % 4 != 0) step();
        clear_counts();
        for (int k = 0; k < 10; k++) begin
            async_in[0] = ~async_in[0];
            repeat (4) step();
        end
        check("bounce level during toggling", level_out, 2'b00);
        async_in = 2'b01;
        repeat (20) step();
        check("bounce level", level_out, 2'b01);
        check("bounce rise count", r0, 1);
        check("bounce fall count", f0, 0);

        // Reset after two disagreeing samples on channel 1 discards the partial count.
        while (cyc % 4 != 0) step();
        async_in = 2'b11;
        repeat (8) step();
        check("midcount level before reset", level_out, 2'b01);
        rst = 1'b0;
        #1;
        check("midcount reset immediate", {level_out, rise_pulse, fall_pulse}, 0);
        nz = 0;
        repeat (3) begin
            step();
            if ({level_out, rise_pulse, fall_pulse} != 6'b0) nz++;
        end
        check("midcount reset hold", nz, 0);
        rst = 1'b1;
        cyc = 0;
        n = 0;
        while (level_out != 2'b11 && n < 25) begin
            step();
            n++;
        end
        check("midcount relatch cycles", n, 12);
        check("midcount rise pulse", rise_pulse, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
